// File: rtl/bp_me_mem_arbiter.sv
// Two-requester (I$/D$) BedRock memory arbiter: round-robin, message-locked forward path
// with an order FIFO that steers in-order memory responses back to the issuing requester.
module bp_me_mem_arbiter #(
  parameter int header_width_p = 64,
  parameter int data_width_p   = 64,
  parameter int order_els_p    = 4
) (
  input  logic                      clk_i,
  input  logic                      reset_i,

  input  logic [header_width_p-1:0] fwd_header_i [2],
  input  logic [data_width_p-1:0]   fwd_data_i   [2],
  input  logic                      fwd_v_i      [2],
  input  logic                      fwd_last_i   [2],
  output logic                      fwd_ready_and_o [2],

  output logic [header_width_p-1:0] mem_fwd_header_o,
  output logic [data_width_p-1:0]   mem_fwd_data_o,
  output logic                      mem_fwd_v_o,
  output logic                      mem_fwd_last_o,
  input  logic                      mem_fwd_ready_and_i,

  input  logic [header_width_p-1:0] mem_rev_header_i,
  input  logic [data_width_p-1:0]   mem_rev_data_i,
  input  logic                      mem_rev_v_i,
  input  logic                      mem_rev_last_i,
  output logic                      mem_rev_ready_and_o,

  output logic [header_width_p-1:0] rev_header_o [2],
  output logic [data_width_p-1:0]   rev_data_o   [2],
  output logic                      rev_v_o      [2],
  output logic                      rev_last_o   [2],
  input  logic                      rev_ready_and_i [2]
);

  localparam int PTR_W = $clog2(order_els_p);
  localparam int CNT_W = $clog2(order_els_p + 1);

  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  state_t           r_state;
  logic             r_lock_id;
  logic             r_rr_last;
  logic             r_fifo [order_els_p];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;

  logic w_empty, w_full, w_head;
  logic w_grant_v, w_grant_id;
  logic w_fwd_acc, w_push, w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(order_els_p - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(order_els_p));
  assign w_head  = r_fifo[r_rptr];

  assign mem_rev_ready_and_o = !reset_i && !w_empty && rev_ready_and_i[w_head];
  assign w_pop = mem_rev_v_i && mem_rev_ready_and_o && mem_rev_last_i;

  // A full FIFO may still accept a new message when a response completes in the same cycle.
  always_comb begin
    w_grant_v  = 1'b0;
    w_grant_id = 1'b0;
    if (!reset_i) begin
      if (r_state == S_LOCKED) begin
        w_grant_v  = 1'b1;
        w_grant_id = r_lock_id;
      end else if (!w_full || w_pop) begin
        if (fwd_v_i[0] && fwd_v_i[1]) begin
          w_grant_v  = 1'b1;
          w_grant_id = ~r_rr_last;
        end else if (fwd_v_i[0]) begin
          w_grant_v  = 1'b1;
          w_grant_id = 1'b0;
        end else if (fwd_v_i[1]) begin
          w_grant_v  = 1'b1;
          w_grant_id = 1'b1;
        end
      end
    end
  end

  assign mem_fwd_v_o      = w_grant_v && fwd_v_i[w_grant_id];
  assign mem_fwd_header_o = fwd_header_i[w_grant_id];
  assign mem_fwd_data_o   = fwd_data_i[w_grant_id];
  assign mem_fwd_last_o   = fwd_last_i[w_grant_id];

  assign w_fwd_acc = mem_fwd_v_o && mem_fwd_ready_and_i;
  assign w_push    = w_fwd_acc && (r_state == S_IDLE);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      assign fwd_ready_and_o[gi] = w_grant_v && (w_grant_id == 1'(gi)) && mem_fwd_ready_and_i;
      assign rev_header_o[gi]    = mem_rev_header_i;
      assign rev_data_o[gi]      = mem_rev_data_i;
      assign rev_last_o[gi]      = mem_rev_last_i;
      assign rev_v_o[gi]         = !reset_i && !w_empty && (w_head == 1'(gi)) && mem_rev_v_i;

      a_fwd_stable: assert property (@(posedge clk_i) disable iff (reset_i)
        (fwd_v_i[gi] && !fwd_ready_and_o[gi]) |=>
          ($stable(fwd_header_i[gi]) && $stable(fwd_data_i[gi])));
    end
  endgenerate

  a_rev_when_empty: assert property (@(posedge clk_i) disable iff (reset_i)
    !(mem_rev_v_i && w_empty));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state   <= S_IDLE;
      r_lock_id <= 1'b0;
      r_rr_last <= 1'b1;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
    end else begin
      // Round-robin pointer only moves when a whole message has gone through.
      if (w_fwd_acc) begin
        if (mem_fwd_last_o) begin
          r_state   <= S_IDLE;
          r_rr_last <= w_grant_id;
        end else begin
          r_state   <= S_LOCKED;
          r_lock_id <= w_grant_id;
        end
      end
      if (w_push) r_wptr <= ptr_inc(r_wptr);
      if (w_pop)  r_rptr <= ptr_inc(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_fifo[r_wptr] <= w_grant_id;
  end

endmodule

// File: doc/bp_me_mem_arbiter.md
BP_ME_MEM_ARBITER -- requirements
Module: bp_me_mem_arbiter

Interface
REQ-001 SHALL have parameter header_width_p, default 64, width of one BedRock memory header.
REQ-002 SHALL have parameter data_width_p, default 64, width of one data beat.
REQ-003 SHALL have parameter order_els_p, default 4, depth of the outstanding-message order FIFO; legal range 2..16.
REQ-004 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_i, input, 1, synchronous active-high reset.
REQ-006 SHALL have ports fwd_header_i[2], fwd_data_i[2], fwd_v_i[2], fwd_last_i[2], input, header_width_p / data_width_p / 1 / 1 each, requester forward stream beats (index 0 = I$, 1 = D$).
REQ-007 SHALL have port fwd_ready_and_o[2], output, 1 each, per-requester ready-and for the forward stream.
REQ-008 SHALL have ports mem_fwd_header_o, mem_fwd_data_o, mem_fwd_v_o, mem_fwd_last_o, output, header_width_p / data_width_p / 1 / 1, merged forward stream to memory.
REQ-009 SHALL have port mem_fwd_ready_and_i, input, 1, memory ready-and.
REQ-010 SHALL have ports mem_rev_header_i, mem_rev_data_i, mem_rev_v_i, mem_rev_last_i, input, header_width_p / data_width_p / 1 / 1, memory reverse stream.
REQ-011 SHALL have port mem_rev_ready_and_o, output, 1, reverse-stream ready-and to memory.
REQ-012 SHALL have ports rev_header_o[2], rev_data_o[2], rev_v_o[2], rev_last_o[2], output, per-requester reverse stream; rev_ready_and_i[2], input, 1 each.

Function
REQ-013 SHALL transfer a beat on any stream only when v and ready_and are both high in the same cycle.
REQ-014 SHALL be in state IDLE when no forward message is in progress, and LOCKED(n) while requester n's message is mid-transfer.
REQ-015 SHALL, in IDLE, grant a requester with fwd_v_i high when the order FIFO is not full; if both are valid, grant the one not granted most recently (round-robin, requester 0 favoured after reset).
REQ-016 SHALL drive mem_fwd_* combinationally from the granted requester's inputs and set fwd_ready_and_o[n] = mem_fwd_ready_and_i for the granted requester only, 0 for the other; zero-latency pass-through.
REQ-017 SHALL push the granted id into the order FIFO on acceptance of a message's first beat, and stall grants (all fwd_ready_and_o = 0, mem_fwd_v_o = 0) in IDLE while the FIFO is full.
REQ-018 SHALL move IDLE -> LOCKED(n) when a first beat of n is accepted with fwd_last_i[n] = 0; SHALL stay in IDLE after a single-beat message (last = 1 on first beat).
REQ-019 SHALL in LOCKED(n) grant only requester n regardless of the other's valid, and return to IDLE on acceptance of n's beat with last = 1.
REQ-020 SHALL update the round-robin pointer only on acceptance of a message's last beat.
REQ-021 SHALL route the reverse stream to the requester at the order FIFO head: rev_*_o[head] = mem_rev_*, rev_v_o[other] = 0, mem_rev_ready_and_o = rev_ready_and_i[head]; memory returns responses in request order.
REQ-022 SHALL hold mem_rev_ready_and_o = 0 and all rev_v_o = 0 while the order FIFO is empty.
REQ-023 SHALL pop the order FIFO on acceptance of a reverse beat with mem_rev_last_i = 1.
REQ-024 SHALL allow push and pop in the same cycle, including when full (pop frees the slot, push then proceeds; count unchanged) and when empty-with-push (no pop possible).
REQ-025 SHALL use a pointer-based FIFO with wrap-around at order_els_p, counter width $clog2(order_els_p+1).
REQ-026 SHALL assert (simulation only) that fwd_header_i/data_i are stable while v high and not ready, and that mem_rev_v_i is never high while the FIFO is empty.

Reset
REQ-027 SHALL, while reset_i is high, force IDLE, FIFO empty, round-robin favouring requester 0, and drive mem_fwd_v_o, mem_rev_ready_and_o, all fwd_ready_and_o and rev_v_o to 0.
REQ-028 SHALL abandon any in-progress message on reset mid-transfer; no partial state survives.

Verification
REQ-029 SHALL pass: both fwd_v_i high with single-beat messages, memory always ready -> grants alternate 0,1,0,1; order FIFO contents 0,1,0,1.
REQ-030 SHALL pass: requester 1 sends a 4-beat message while requester 0 is valid throughout -> all 4 beats of requester 1 reach memory contiguously before any beat of 0.
REQ-031 SHALL pass: order_els_p = 4, five single-beat requests, no responses -> fifth stalls (fwd_ready_and_o = 0) until one last reverse beat pops, then is accepted.
REQ-032 SHALL pass: FIFO holds ids 1,0; memory returns a 2-beat then a 1-beat response -> beats appear on rev_*_o[1] then rev_*_o[0]; rev_ready_and_i[1] low stalls mem_rev_ready_and_o.
REQ-033 SHALL pass: full FIFO, simultaneous last reverse beat and new first forward beat -> both accepted in same cycle, count stays 4.
REQ-034 SHALL pass: reset_i asserted during beat 2 of a 4-beat message -> next cycle all outputs 0, state IDLE, FIFO empty.
